// File: rtl/tabela_scan.sv
// tabela_scan: steps shared p/q through rows 00,01,10,11, captures each
// candidate's s into a 4-bit truth vector and compares it to an expected one.

// One candidate: owns its captured truth vector and the compare against expected.
module tabela_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       smp,
    input  logic [1:0] row,
    input  logic       s,
    input  logic [3:0] exp_vec,
    output logic [3:0] vec,
    output logic       hit
);
    // capture s into the bit addressed by the current row; cleared on scan start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vec <= '0;
        else if (clr)    vec <= '0;
        else if (smp)    vec[row] <= s;
    end

    assign hit = (vec == exp_vec);
endmodule

module tabela_scan #(
    parameter int NCAND  = 3,
    parameter int SETTLE = 1,
    localparam int IDXW  = (NCAND > 1) ? $clog2(NCAND) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           expected,
    input  logic [NCAND-1:0]     s_in,
    output logic                 p,
    output logic                 q,
    output logic                 busy,
    output logic                 done,
    output logic [4*NCAND-1:0]   vec,
    output logic [NCAND-1:0]     match,
    output logic                 any_match,
    output logic [IDXW-1:0]      first_idx
);
    localparam int CNTW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, ROW, CMP} state_t;

    state_t                  state, state_n;
    logic [1:0]              row;
    logic [CNTW-1:0]         cnt;
    logic [3:0]              exp_q;
    logic                    clr, smp, cmp;
    logic [NCAND-1:0]        hits;
    logic [NCAND-1:0][3:0]   vec_l;
    logic [IDXW-1:0]         hit_idx;

    // per-candidate capture/compare lanes
    for (genvar k = 0; k < NCAND; k++) begin : g_lane
        tabela_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .smp     (smp),
            .row     (row),
            .s       (s_in[k]),
            .exp_vec (exp_q),
            .vec     (vec_l[k]),
            .hit     (hits[k])
        );
    end

    assign vec = vec_l;

    // next-state and strobes; a row is sampled once its settle count expires
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        smp     = 1'b0;
        cmp     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = ROW;
                clr     = 1'b1;
            end
            ROW: if (cnt == CNTW'(SETTLE)) begin
                smp = 1'b1;
                if (row == 2'd3) state_n = CMP;
            end
            CMP: begin
                cmp     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, row/settle counters and the expected pattern latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            cnt   <= '0;
            exp_q <= '0;
        end else begin
            state <= state_n;
            if (clr) begin
                exp_q <= expected;
                row   <= '0;
                cnt   <= '0;
            end else if (state == ROW) begin
                if (smp) begin
                    cnt <= '0;
                    if (row != 2'd3) row <= row + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // lowest matching candidate wins
    always_comb begin
        hit_idx = '0;
        for (int k = NCAND - 1; k >= 0; k--)
            if (hits[k]) hit_idx = IDXW'(k);
    end

    // results update only in CMP and hold until the next compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            match     <= '0;
            any_match <= 1'b0;
            first_idx <= '0;
        end else begin
            done <= cmp;
            if (cmp) begin
                match     <= hits;
                any_match <= |hits;
                first_idx <= hit_idx;
            end
        end
    end

    // p/q follow the row only while stepping; parked at 00 otherwise
    assign p    = (state == ROW) & row[1];
    assign q    = (state == ROW) & row[0];
    assign busy = (state != IDLE);
endmodule
